// File: rtl/cam_pkg.sv
// Shared types and sizing helpers for the slice-RAM CAM.
// Pulled in by the slice RAM and the engine top level.
package cam_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        CLEAR,
        SET
    } cam_state_t;

    // The last slice is zero-padded when DATA_WIDTH is not a multiple of SLICE_WIDTH.
    function automatic int slice_count(input int data_width, input int slice_width);
        return (data_width + slice_width - 1) / slice_width;
    endfunction

    function automatic int row_count(input int slice_width);
        return 1 << slice_width;
    endfunction

endpackage

// File: rtl/cam_slice_ram.sv
// One key slice: a 2^SLICE_WIDTH x 2^ADDR_WIDTH bit-vector RAM with a single-bit
// write port, a whole-row clear port and a registered full-row read port.
module cam_slice_ram
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_en,
    input  logic [SLICE_WIDTH-1:0]     clr_row,
    input  logic                       bit_en,
    input  logic [SLICE_WIDTH-1:0]     bit_row,
    input  logic [ADDR_WIDTH-1:0]      bit_col,
    input  logic                       bit_val,
    input  logic                       rd_en,
    input  logic [SLICE_WIDTH-1:0]     rd_row,
    output logic [(1<<ADDR_WIDTH)-1:0] rd_data
);

    localparam int ROWS    = row_count(SLICE_WIDTH);
    localparam int ENTRIES = 1 << ADDR_WIDTH;

    logic [ENTRIES-1:0] mem [ROWS];

    // Row clear wins; the sequencer never asserts both in the same cycle anyway.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_row] <= '0;
        end else if (bit_en) begin
            mem[bit_row][bit_col] <= bit_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_row];
        end
    end

endmodule

// File: rtl/cam_slice_engine.sv
// Slice-RAM CAM: write/erase sequencer (INIT/IDLE/CLEAR/SET) plus a two-stage
// search pipeline (slice read, then AND + priority encode + multi-match).
module cam_slice_engine
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_erase,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  srch_valid,
    output logic                  srch_ready,
    input  logic [DATA_WIDTH-1:0] srch_data,
    output logic                  res_valid,
    output logic                  res_match,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic                  res_multi
);

    localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH);
    localparam int ROWS        = row_count(SLICE_WIDTH);
    localparam int ENTRIES     = 1 << ADDR_WIDTH;
    localparam int KEY_WIDTH   = SLICE_COUNT * SLICE_WIDTH;

    cam_state_t state, state_next;

    logic [SLICE_WIDTH-1:0] row_cnt;
    logic                   row_last;
    logic                   lat_erase;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [KEY_WIDTH-1:0]   lat_key;
    logic [KEY_WIDTH-1:0]   srch_key;
    logic                   wr_accept;
    logic                   srch_accept;
    logic                   init_clr;
    logic                   bit_en;
    logic                   bit_val;

    logic                                     s1_valid;
    logic [SLICE_COUNT-1:0][ENTRIES-1:0]      rd_vec;
    logic [ENTRIES-1:0]                       hit_vec;
    logic                                     hit_any;
    logic                                     hit_multi;
    logic [ADDR_WIDTH-1:0]                    hit_addr;

    assign srch_key    = KEY_WIDTH'(srch_data);
    assign row_last    = (row_cnt == SLICE_WIDTH'(ROWS - 1));
    assign wr_accept   = wr_valid & wr_ready;
    assign srch_accept = srch_valid & srch_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (row_last) state_next = IDLE;
            IDLE:    if (wr_accept) state_next = CLEAR;
            CLEAR:   if (row_last) state_next = lat_erase ? IDLE : SET;
            SET:     state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    // Search has priority over a simultaneous write request.
    always_comb begin
        srch_ready = 1'b0;
        wr_ready   = 1'b0;
        init_clr   = 1'b0;
        bit_en     = 1'b0;
        bit_val    = 1'b0;
        case (state)
            INIT:  init_clr = 1'b1;
            IDLE: begin
                srch_ready = 1'b1;
                wr_ready   = !srch_valid;
            end
            CLEAR: bit_en = 1'b1;
            SET: begin
                bit_en  = 1'b1;
                bit_val = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (state == INIT || state == CLEAR) begin
            row_cnt <= row_cnt + SLICE_WIDTH'(1);
        end else begin
            row_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_erase <= 1'b0;
            lat_addr  <= '0;
            lat_key   <= '0;
        end else if (wr_accept) begin
            lat_erase <= wr_erase;
            lat_addr  <= wr_addr;
            lat_key   <= KEY_WIDTH'(wr_data);
        end
    end

    for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
        logic [SLICE_WIDTH-1:0] bit_row;

        // CLEAR sweeps every row; SET touches only the row named by the key slice.
        assign bit_row = (state == SET) ? lat_key[s*SLICE_WIDTH +: SLICE_WIDTH] : row_cnt;

        cam_slice_ram #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .SLICE_WIDTH (SLICE_WIDTH)
        ) u_ram (
            .clk     (clk),
            .clr_en  (init_clr),
            .clr_row (row_cnt),
            .bit_en  (bit_en),
            .bit_row (bit_row),
            .bit_col (lat_addr),
            .bit_val (bit_val),
            .rd_en   (srch_accept),
            .rd_row  (srch_key[s*SLICE_WIDTH +: SLICE_WIDTH]),
            .rd_data (rd_vec[s])
        );
    end

    always_comb begin
        hit_vec = '1;
        for (int s = 0; s < SLICE_COUNT; s++) begin
            hit_vec = hit_vec & rd_vec[s];
        end
        hit_addr = '0;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (hit_vec[e]) hit_addr = ADDR_WIDTH'(e);
        end
        hit_any   = |hit_vec;
        hit_multi = |(hit_vec & (hit_vec - ENTRIES'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            res_addr  <= '0;
            res_multi <= 1'b0;
        end else begin
            s1_valid  <= srch_accept;
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_match <= hit_any;
                res_addr  <= hit_addr;
                res_multi <= hit_multi;
            end
        end
    end

endmodule
